ff_pipe: RTL

- Parametrised successor to the single-bit D flip-flop used across the PWM datapath.
- WIDTH-bit, DEPTH-stage register pipeline with:
  - asynchronous reset to a programmable value
  - clock enable (stall)
  - synchronous flush
  - per-stage valid tracking and an occupancy counter
  - selectable tap readout
- Used to align duty/period words and comparator outputs across PWM channels.

---
 rtl/ff_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ff_pipe.sv
// ff_pipe: WIDTH-bit, DEPTH-stage register pipeline with async reset to
// RST_VAL, stall (en), sync flush, per-stage valid bits, an occupancy
// counter and a saturating tap readout.
// Optional q[0] edge strobes (rise/fall) are built when FF_PIPE_EDGE_EN
// is defined. Otherwise the ports exist and are tied low.

// One pipeline stage: data plus its valid bit, with flush taking
// priority over shift.
module ff_pipe_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] dat_d, dat_q;
  logic             vld_d, vld_q;

  // next-state: flush clears, enable shifts, otherwise hold
  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (flush) begin
      dat_d = RST_VAL;
      vld_d = 1'b0;
    end else if (en) begin
      dat_d = d;
      vld_d = d_valid;
    end
  end

  // stage registers, async reset to the programmable value
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      dat_q <= RST_VAL;
      vld_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign q       = dat_q;
  assign q_valid = vld_q;

endmodule

module ff_pipe #(
  parameter  int               WIDTH   = 8,
  parameter  int               DEPTH   = 4,
  parameter  logic [WIDTH-1:0] RST_VAL = '0,
  localparam int               TAP_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int               CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] tap_q,
  output logic [CNT_W-1:0] count,
  output logic             rise,
  output logic             fall
);

  // s/v are the stage outputs; s_in/v_in are what each stage captures
  logic [DEPTH-1:0][WIDTH-1:0] s, s_in;
  logic [DEPTH-1:0]            v, v_in;

  assign s_in[0] = d;
  assign v_in[0] = d_valid;

  // stage chain: stage i captures stage i-1 (stage 0 captures d)
  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    if (i > 0) begin : g_link
      assign s_in[i] = s[i-1];
      assign v_in[i] = v[i-1];
    end
    ff_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stg (
      .ck      (ck),
      .rst     (rst),
      .en      (en),
      .flush   (flush),
      .d       (s_in[i]),
      .d_valid (v_in[i]),
      .q       (s[i]),
      .q_valid (v[i])
    );
  end

  assign q       = s[DEPTH-1];
  assign q_valid = v[DEPTH-1];

  // Occupancy: +1 for a valid word entering, -1 for a valid word leaving.
  // A full pipe can only accept a new valid word while one leaves, so
  // the count never wraps.
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // occupancy next-state
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(d_valid) - CNT_W'(v[DEPTH-1]);
    end
  end

  // occupancy register
  always_ff @(posedge ck or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

  // tap mux: out-of-range selects fall back to the last stage
  always_comb begin
    tap_q = s[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(tap_sel) == i) tap_q = s[i];
    end
  end

`ifdef FF_PIPE_EDGE_EN
  // h holds q[0] as it was before the most recent enabled shift
  logic h_d, h_q;

  // edge history next-state: flush reloads the reset bit
  always_comb begin
    h_d = h_q;
    if (flush)   h_d = RST_VAL[0];
    else if (en) h_d = s[DEPTH-1][0];
  end

  // edge history register
  always_ff @(posedge ck or posedge rst) begin
    if (rst) h_q <= RST_VAL[0];
    else     h_q <= h_d;
  end

  // Both inputs are flops that move together, so each strobe lasts
  // exactly one shift and holds through a stall.
  assign rise = s[DEPTH-1][0] & ~h_q;
  assign fall = ~s[DEPTH-1][0] & h_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule
